// File: rtl/object_renderer.sv
// ============================================================================
// object_renderer : sweeps object, erase and fill rectangles one pixel/clock
// Rev 1.0
// ============================================================================
`default_nettype none

module object_renderer #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [3:0]  objectToDraw,
    input  logic        inEraseState,
    input  logic        inDrawStartScreenState,
    input  logic        inDrawGameoverScreenState,
    input  logic [7:0]  playerX,
    input  logic [6:0]  playerY,
    input  logic [31:0] enemyX,
    input  logic [27:0] enemyY,
    input  logic [7:0]  bulletX,
    input  logic [6:0]  bulletY,
    input  logic [3:0]  playerHealth,
    output logic [7:0]  x,
    output logic [6:0]  y,
    output logic [2:0]  colour,
    output logic        pixelValid,
    output logic        doneDrawing,
    output logic        doneErasing
);

    localparam logic [8:0] X_LIMIT  = 9'(SCREEN_W);
    localparam logic [7:0] Y_LIMIT  = 8'(SCREEN_H);
    localparam logic [7:0] FULL_WM1 = 8'(SCREEN_W - 1);
    localparam logic [6:0] FULL_HM1 = 7'(SCREEN_H - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2,
        FILL  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  org_x_q, org_x_d;
    logic [6:0]  org_y_q, org_y_d;
    logic [7:0]  wm1_q, wm1_d;
    logic [6:0]  hm1_q, hm1_d;
    logic [7:0]  col_q, col_d;
    logic [6:0]  row_q, row_d;
    logic        erase_q, erase_d;
    logic        fill_over_q, fill_over_d;
    logic [7:0]  x_q, x_d;
    logic [6:0]  y_q, y_d;
    logic [2:0]  colour_q, colour_d;
    logic        valid_q, valid_d;
    logic        done_draw_q, done_draw_d;
    logic        done_erase_q, done_erase_d;

    // Decoded geometry of the object code currently requested
    logic [7:0]  dec_x;
    logic [6:0]  dec_y;
    logic [7:0]  dec_wm1;
    logic [6:0]  dec_hm1;
    logic [2:0]  dec_colour;
    logic        dec_empty;
    logic [1:0]  enemy_idx;
    logic [1:0]  hud_slot;

    always_comb begin
        dec_x      = 8'd0;
        dec_y      = 7'd0;
        dec_wm1    = 8'd0;
        dec_hm1    = 7'd0;
        dec_colour = 3'b000;
        dec_empty  = 1'b0;
        enemy_idx  = objectToDraw[1:0] - 2'd2;
        // Markers (odd 7..13) and cells (even 8..14) share the same slot mapping
        hud_slot   = 2'((objectToDraw - 4'd7) >> 1);
        case (objectToDraw)
            4'd1: begin
                dec_x      = playerX;
                dec_y      = playerY;
                dec_wm1    = 8'd7;
                dec_hm1    = 7'd7;
                dec_colour = 3'b111;
            end
            4'd2, 4'd3, 4'd4, 4'd5: begin
                dec_x      = enemyX[8*enemy_idx +: 8];
                dec_y      = enemyY[7*enemy_idx +: 7];
                dec_wm1    = 8'd7;
                dec_hm1    = 7'd7;
                dec_colour = 3'b100;
            end
            4'd6: begin
                dec_x      = bulletX;
                dec_y      = bulletY;
                dec_wm1    = 8'd0;
                dec_hm1    = 7'd3;
                dec_colour = 3'b110;
            end
            4'd7, 4'd9, 4'd11, 4'd13: begin
                dec_x      = 8'd4 + {3'b000, hud_slot, 3'b000};
                dec_y      = 7'd2;
                dec_wm1    = 8'd5;
                dec_hm1    = 7'd5;
                dec_colour = 3'b111;
            end
            4'd8, 4'd10, 4'd12, 4'd14: begin
                dec_x      = 8'd5 + {3'b000, hud_slot, 3'b000};
                dec_y      = 7'd3;
                dec_wm1    = 8'd3;
                dec_hm1    = 7'd3;
                dec_colour = (playerHealth > {2'b00, hud_slot}) ? 3'b010 : 3'b000;
            end
            4'd15: dec_empty = 1'b1;
            default: ;
        endcase
    end

    logic       emit;
    logic       last_px;
    logic       fill_req;
    logic [8:0] sum_x;
    logic [7:0] sum_y;

    always_comb begin
        state_d      = state_q;
        org_x_d      = org_x_q;
        org_y_d      = org_y_q;
        wm1_d        = wm1_q;
        hm1_d        = hm1_q;
        col_d        = col_q;
        row_d        = row_q;
        erase_d      = erase_q;
        fill_over_d  = fill_over_q;
        x_d          = x_q;
        y_d          = y_q;
        colour_d     = colour_q;
        valid_d      = 1'b0;
        done_draw_d  = 1'b0;
        done_erase_d = 1'b0;
        emit         = 1'b0;
        last_px      = (col_q == wm1_q) && (row_q == hm1_q);
        fill_req     = fill_over_q ? inDrawGameoverScreenState : inDrawStartScreenState;

        case (state_q)
            IDLE: begin
                col_d = 8'd0;
                row_d = 7'd0;
                if (inEraseState || inDrawStartScreenState || inDrawGameoverScreenState) begin
                    org_x_d     = 8'd0;
                    org_y_d     = 7'd0;
                    wm1_d       = FULL_WM1;
                    hm1_d       = FULL_HM1;
                    emit        = 1'b1;
                    erase_d     = inEraseState;
                    fill_over_d = !inDrawStartScreenState;
                    if (inEraseState) begin
                        colour_d = 3'b000;
                        state_d  = SWEEP;
                    end else begin
                        colour_d = inDrawStartScreenState ? 3'b001 : 3'b100;
                        state_d  = FILL;
                    end
                end else if (objectToDraw != 4'd0) begin
                    erase_d = 1'b0;
                    if (dec_empty) begin
                        done_draw_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        org_x_d  = dec_x;
                        org_y_d  = dec_y;
                        wm1_d    = dec_wm1;
                        hm1_d    = dec_hm1;
                        colour_d = dec_colour;
                        emit     = 1'b1;
                        state_d  = SWEEP;
                    end
                end
            end
            SWEEP: begin
                if (last_px) begin
                    done_erase_d = erase_q;
                    done_draw_d  = !erase_q;
                    state_d      = DONE;
                end else begin
                    emit = 1'b1;
                    if (col_q == wm1_q) begin
                        col_d = 8'd0;
                        row_d = row_q + 7'd1;
                    end else begin
                        col_d = col_q + 8'd1;
                    end
                end
            end
            DONE: begin
                // Wait for the sequencer to drop its request before re-arming
                if (erase_q ? !inEraseState : (objectToDraw == 4'd0))
                    state_d = IDLE;
            end
            FILL: begin
                if (fill_req) begin
                    emit = 1'b1;
                    if (last_px) begin
                        col_d = 8'd0;
                        row_d = 7'd0;
                    end else if (col_q == wm1_q) begin
                        col_d = 8'd0;
                        row_d = row_q + 7'd1;
                    end else begin
                        col_d = col_q + 8'd1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        sum_x = {1'b0, org_x_d} + {1'b0, col_d};
        sum_y = {1'b0, org_y_d} + {1'b0, row_d};
        if (emit) begin
            x_d     = sum_x[7:0];
            y_d     = sum_y[6:0];
            valid_d = (sum_x < X_LIMIT) && (sum_y < Y_LIMIT);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= IDLE;
            org_x_q      <= 8'd0;
            org_y_q      <= 7'd0;
            wm1_q        <= 8'd0;
            hm1_q        <= 7'd0;
            col_q        <= 8'd0;
            row_q        <= 7'd0;
            erase_q      <= 1'b0;
            fill_over_q  <= 1'b0;
            x_q          <= 8'd0;
            y_q          <= 7'd0;
            colour_q     <= 3'b000;
            valid_q      <= 1'b0;
            done_draw_q  <= 1'b0;
            done_erase_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            org_x_q      <= org_x_d;
            org_y_q      <= org_y_d;
            wm1_q        <= wm1_d;
            hm1_q        <= hm1_d;
            col_q        <= col_d;
            row_q        <= row_d;
            erase_q      <= erase_d;
            fill_over_q  <= fill_over_d;
            x_q          <= x_d;
            y_q          <= y_d;
            colour_q     <= colour_d;
            valid_q      <= valid_d;
            done_draw_q  <= done_draw_d;
            done_erase_q <= done_erase_d;
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign colour      = colour_q;
    assign pixelValid  = valid_q;
    assign doneDrawing = done_draw_q;
    assign doneErasing = done_erase_q;

endmodule

`default_nettype wire

// File: tb/tb_object_renderer.sv
// ============================================================================
// tb_object_renderer : directed self-checking bench for object_renderer
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_object_renderer;

    logic        clk;
    logic        resetn;
    logic [3:0]  objectToDraw;
    logic        inEraseState;
    logic        inDrawStartScreenState;
    logic        inDrawGameoverScreenState;
    logic [7:0]  playerX;
    logic [6:0]  playerY;
    logic [31:0] enemyX;
    logic [27:0] enemyY;
    logic [7:0]  bulletX;
    logic [6:0]  bulletY;
    logic [3:0]  playerHealth;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        pixelValid;
    logic        doneDrawing;
    logic        doneErasing;

    int n_checks = 0;
    int n_fail   = 0;

    object_renderer #(.SCREEN_W(160), .SCREEN_H(120)) dut (
        .clk                       (clk),
        .resetn                    (resetn),
        .objectToDraw              (objectToDraw),
        .inEraseState              (inEraseState),
        .inDrawStartScreenState    (inDrawStartScreenState),
        .inDrawGameoverScreenState (inDrawGameoverScreenState),
        .playerX                   (playerX),
        .playerY                   (playerY),
        .enemyX                    (enemyX),
        .enemyY                    (enemyY),
        .bulletX                   (bulletX),
        .bulletY                   (bulletY),
        .playerHealth              (playerHealth),
        .x                         (x),
        .y                         (y),
        .colour                    (colour),
        .pixelValid                (pixelValid),
        .doneDrawing               (doneDrawing),
        .doneErasing               (doneErasing)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {doneErasing, doneDrawing, pixelValid, colour, y, x}
    function automatic logic [20:0] pix();
        return {doneErasing, doneDrawing, pixelValid, colour, y, x};
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic run_object(input logic [3:0] code, input int ox, input int oy,
                              input int w, input int h, input logic [2:0] col);
        int   ex;
        int   ey;
        logic v;
        objectToDraw = code;
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                tick();
                ex = ox + c;
                ey = oy + r;
                v  = (ex < 160) && (ey < 120);
                check("obj_px", {11'd0, pix()}, {11'd0, 2'b00, v, col, ey[6:0], ex[7:0]});
            end
        end
        tick();
        check("obj_done", {29'd0, doneErasing, doneDrawing, pixelValid}, 32'b010);
        tick();
        check("obj_hold", {11'd0, pix()}, {11'd0, 3'b000, col, ey[6:0], ex[7:0]});
        objectToDraw = 4'd0;
        tick();
        check("obj_rearm", {29'd0, doneErasing, doneDrawing, pixelValid}, 32'b000);
    endtask

    initial begin
        resetn = 1'b0;
        objectToDraw = 4'd0;
        inEraseState = 1'b0;
        inDrawStartScreenState = 1'b0;
        inDrawGameoverScreenState = 1'b0;
        playerX = 8'd0;
        playerY = 7'd0;
        enemyX = 32'd0;
        enemyY = 28'd0;
        bulletX = 8'd0;
        bulletY = 7'd0;
        playerHealth = 4'd0;

        repeat (3) tick();
        check("reset", {11'd0, pix()}, 32'd0);
        resetn = 1'b1;
        tick();
        check("idle", {11'd0, pix()}, 32'd0);

        // Player sweep, then the same code again once it has returned to 0
        playerX = 8'd10;
        playerY = 7'd20;
        run_object(4'd1, 10, 20, 8, 8, 3'b111);
        run_object(4'd1, 10, 20, 8, 8, 3'b111);

        // Full-screen erase
        inEraseState = 1'b1;
        for (int r = 0; r < 120; r++) begin
            for (int c = 0; c < 160; c++) begin
                tick();
                check("erase_px", {11'd0, pix()}, {11'd0, 3'b001, 3'b000, 7'(r), 8'(c)});
            end
        end
        tick();
        check("erase_done", {29'd0, doneErasing, doneDrawing, pixelValid}, 32'b100);
        tick();
        check("erase_hold", {11'd0, pix()}, {11'd0, 3'b000, 3'b000, 7'd119, 8'd159});
        inEraseState = 1'b0;
        tick();

        // Health cells and a marker
        playerHealth = 4'd2;
        run_object(4'd8,  5,  3, 4, 4, 3'b010);
        run_object(4'd10, 13, 3, 4, 4, 3'b010);
        run_object(4'd12, 21, 3, 4, 4, 3'b000);
        run_object(4'd9,  12, 2, 6, 6, 3'b111);

        // Bullet running off the bottom edge
        bulletX = 8'd159;
        bulletY = 7'd118;
        run_object(4'd6, 159, 118, 1, 4, 3'b110);

        // Code 15: empty object
        objectToDraw = 4'd15;
        tick();
        check("empty_done", {29'd0, doneErasing, doneDrawing, pixelValid}, 32'b010);
        tick();
        check("empty_hold", {29'd0, doneErasing, doneDrawing, pixelValid}, 32'b000);
        objectToDraw = 4'd0;
        tick();

        // Start screen wins over game-over screen
        inDrawStartScreenState = 1'b1;
        inDrawGameoverScreenState = 1'b1;
        tick();
        check("start_px0", {11'd0, pix()}, {11'd0, 3'b001, 3'b001, 7'd0, 8'd0});
        tick();
        check("start_px1", {11'd0, pix()}, {11'd0, 3'b001, 3'b001, 7'd0, 8'd1});
        inDrawStartScreenState = 1'b0;
        inDrawGameoverScreenState = 1'b0;
        tick();
        check("start_exit", {29'd0, doneErasing, doneDrawing, pixelValid}, 32'b000);

        // Game-over fill with wrap-around
        inDrawGameoverScreenState = 1'b1;
        for (int i = 0; i < 19210; i++) begin
            tick();
            check("over_px", {11'd0, pix()},
                  {11'd0, 3'b001, 3'b100, 7'((i / 160) % 120), 8'(i % 160)});
        end
        inDrawGameoverScreenState = 1'b0;
        tick();
        check("over_exit", {29'd0, doneErasing, doneDrawing, pixelValid}, 32'b000);

        // Enemy 2 sweep aborted by reset at pixel 30
        enemyX = {8'd0, 8'd0, 8'd40, 8'd0};
        enemyY = {7'd0, 7'd0, 7'd50, 7'd0};
        objectToDraw = 4'd3;
        for (int i = 0; i < 30; i++) begin
            tick();
            check("enemy_px", {11'd0, pix()},
                  {11'd0, 3'b001, 3'b100, 7'(50 + i / 8), 8'(40 + i % 8)});
        end
        resetn = 1'b0;
        tick();
        check("abort_reset", {11'd0, pix()}, 32'd0);
        objectToDraw = 4'd0;
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("abort_quiet", {11'd0, pix()}, 32'd0);
        end
        run_object(4'd3, 40, 50, 8, 8, 3'b100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
